fsm_inic_ram_param: RTL and testbench
=====================================

Name: fsm_inic_ram_param

Overview:
- Parametrised RAM-initialisation sequencer; next generation of the fixed 32-entry one-hot init FSM.
- On a start request it copies a ROM image into RAM, or fills RAM with a constant, using binary addresses and configurable depth and width.
- An optional readback-verify pass reports the first mismatching address.
- Sits between the control FSM, the init ROM and the register RAM of the RTC controller.

Parameters:
- DEPTH, 32, number of RAM words initialised (2..2**ADDR_W)
- ADDR_W, 5, RAM and ROM address width
- DATA_W, 8, data word width
- VERIFY_EN, 1, 1 builds the readback-verify phase; 0 removes it (verify input ignored)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- mode  in  1  0 = copy ROM[i] to RAM[i]; 1 = fill with fill_value; latched at start
- verify  in  1  request verify pass after writing; latched at start
- fill_value  in  DATA_W  constant for fill mode; latched at start
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM data, valid 1 cycle after rom_en
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_re
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle pulse at completion
- err  out  1  verify mismatch flag; held until next accepted start
- err_addr  out  ADDR_W  address of the first mismatch; held with err

Behaviour:
- Reset (reset=0, async): state=IDLE, counters=0. All outputs 0, including err and err_addr.
- IDLE:
  - Strobes are 0 and busy=0.
  - start=1 latches mode, verify and fill_value, clears err and err_addr, sets cnt=0, and goes to WRITE.
- WRITE (two-stage pipeline):
  - Issue stage: while cnt<DEPTH, drive rom_en=1 (copy mode only) and rom_addr=cnt, then increment cnt.
  - Write stage, one cycle later: ram_we=1, ram_addr=issued address, ram_wdata=rom_data (copy) or latched fill_value (fill).
  - Timing is identical in both modes. Writes occur on the 2nd through (DEPTH+1)th cycles after acceptance, one word per cycle with no gaps, at addresses 0..DEPTH-1 ascending.
  - After the last write: go to VERIFY if VERIFY_EN=1 and verify was latched, otherwise go to DONE.
- VERIFY:
  - Issue stage: ram_re=1 and ram_addr=cnt; in copy mode also rom_en=1 and rom_addr=cnt.
  - Compare stage, one cycle later: compare ram_rdata against rom_data (copy) or fill_value (fill).
  - On the first mismatch: set err=1, latch err_addr, stop issuing, and go to DONE. Reads already in flight are discarded.
  - If all DEPTH words match, go to DONE with err=0.
- DONE: done=1 for exactly one cycle, busy=1 in that cycle, then IDLE.
- Strobe exclusivity: ram_we and ram_re are never high together.
- Counter and width rules:
  - Counter width is ADDR_W+1, so DEPTH=2**ADDR_W terminates without wrap.
  - Addresses are zero-extended truncations of the counter.
- Busy behaviour: start while busy is ignored; mode, verify and fill_value changes mid-operation have no effect.
- Reset mid-operation: immediate return to IDLE. Any partial RAM contents are left as written. No done pulse.
- Start in the same cycle DONE exits is not accepted; start is accepted from IDLE on the following cycle.
- Total latency from start to done:
  - without verify: DEPTH+2 cycles
  - with verify and no error: 2·DEPTH+3 cycles

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, WRITE, VERIFY, DONE
  - mode constants: MODE_COPY=0, MODE_FILL=1
  - default DEPTH, ADDR_W and DATA_W for the RTC register map (32/5/8)
- Natural sub-module: init_addr_pipe. It is the issue counter plus the one-stage valid/address delay register, reused by the WRITE and VERIFY phases.
- The FSM and the compare logic stay in the top module.

Test Plan:
- Copy, no verify. ROM[i]=i+8'h10, DEPTH=32, pulse start → 32 consecutive ram_we cycles starting on cycle 2, addresses 0..31, data 8'h10..8'h2F; done on cycle 34; err=0.
- Fill with verify. fill_value=8'hA5, RAM model correct, start → 32 writes of A5, then 32 ram_re reads; done at cycle 67; err=0.
- Verify mismatch. Copy mode with verify, RAM model corrupts address 7 (writes 8'hFF) → err=1, err_addr=7, no ram_re issued after address 8, single done pulse.
- Reset mid-write. Assert reset=0 at write of address 12 → all outputs 0 asynchronously, no done. After release, a new start restarts at address 0.
- Start during busy and back-to-back. Pulse start at cycle 5 of an operation → ignored, exactly 32 writes. Start asserted during the DONE cycle → ignored; start on the next cycle → accepted.
- Parameter sweep. DEPTH=16, ADDR_W=4, DATA_W=16, VERIFY_EN=0 → 16 writes, counter does not wrap, verify input ignored, done at cycle 18.

Source files
------------

// File: rtl/fsm_inic_ram_param_pkg.sv
// Shared types and defaults for the RAM-initialisation sequencer.
// Defaults match the RTC register map.
package fsm_inic_ram_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/fsm_inic_ram_param_addr_pipe.sv
// Issue counter plus one-stage valid/address delay.
// Shared by the write and verify phases.
module init_addr_pipe #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              issue,
    output logic [CNT_W-1:0]  cnt,
    output logic              vld,
    output logic [ADDR_W-1:0] addr
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        cnt_d  = cnt_q;
        vld_d  = issue & ~clr;
        addr_d = addr_q;
        if (clr) begin
            cnt_d = '0;
        end else if (issue) begin
            cnt_d  = cnt_q + CNT_W'(1);
            addr_d = cnt_q[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign cnt  = cnt_q;
    assign vld  = vld_q;
    assign addr = addr_q;

endmodule

// File: rtl/fsm_inic_ram_param.sv
// RAM-initialisation sequencer: copy ROM or fill constant,
// with optional readback verify reporting the first bad address.
module fsm_inic_ram_param
    import fsm_inic_ram_param_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              verify,
    input  logic [DATA_W-1:0] fill_value,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic              verify_q, verify_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              clr, issue, more, vld;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] pipe_addr, cur_addr;
    logic [DATA_W-1:0] ref_data;

    init_addr_pipe #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_pipe (
        .clk   (clk),
        .rst_n (reset),
        .clr   (clr),
        .issue (issue),
        .cnt   (cnt),
        .vld   (vld),
        .addr  (pipe_addr)
    );

    assign more     = cnt < LAST;
    assign cur_addr = cnt[ADDR_W-1:0];
    assign ref_data = (mode_q == MODE_FILL) ? fill_q : rom_data;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        verify_d   = verify_q;
        fill_d     = fill_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        clr        = 1'b0;
        issue      = 1'b0;
        rom_en     = 1'b0;
        rom_addr   = '0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (start) begin
                    state_d    = WRITE;
                    mode_d     = mode;
                    verify_d   = verify;
                    fill_d     = fill_value;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end
            end
            WRITE: begin
                issue = more;
                if (more) begin
                    rom_en   = (mode_q == MODE_COPY);
                    rom_addr = cur_addr;
                end
                if (vld) begin
                    ram_we    = 1'b1;
                    ram_addr  = pipe_addr;
                    ram_wdata = ref_data;
                end
                if (vld && !more) begin
                    if (VERIFY_EN != 0 && verify_q) begin
                        state_d = VERIFY;
                        clr     = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            VERIFY: begin
                issue = more;
                if (more) begin
                    ram_re   = 1'b1;
                    ram_addr = cur_addr;
                    rom_en   = (mode_q == MODE_COPY);
                    rom_addr = cur_addr;
                end
                // Any read still in flight after a mismatch is dropped in DONE
                if (vld) begin
                    if (ram_rdata != ref_data) begin
                        err_d      = 1'b1;
                        err_addr_d = pipe_addr;
                        state_d    = DONE;
                    end else if (!more) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_COPY;
            verify_q   <= 1'b0;
            fill_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            verify_q   <= verify_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_fsm_inic_ram_param.sv
// Directed bench for the RAM-init sequencer: default build
// plus a 16-deep, 16-bit build without verify.
module tb_fsm_inic_ram_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       start = 0, mode = 0, verify = 0;
    logic [7:0] fv = 0;
    logic       rom_en, ram_we, ram_re, busy, done, err;
    logic [4:0] rom_addr, ram_addr, err_addr;
    logic [7:0] rom_data = 0, ram_rdata = 0, ram_wdata;
    logic [7:0] mem [32];
    logic       corrupt = 0;

    fsm_inic_ram_param dut_a (
        .clk(clk), .reset(rst_n), .start(start), .mode(mode),
        .verify(verify), .fill_value(fv), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .ram_we(ram_we),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .done(done), .err(err),
        .err_addr(err_addr)
    );

    always @(posedge clk) begin
        if (rom_en) rom_data <= 8'(rom_addr) + 8'h10;
        if (ram_we) mem[ram_addr] <= (corrupt && ram_addr == 5'd7) ? 8'hFF : ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    logic        start_b = 0, mode_b = 0, verify_b = 0;
    logic [15:0] fv_b = 0, rom_data_b = 0, ram_rdata_b = 0, ram_wdata_b;
    logic        rom_en_b, ram_we_b, ram_re_b, busy_b, done_b, err_b;
    logic [3:0]  rom_addr_b, ram_addr_b, err_addr_b;

    fsm_inic_ram_param #(
        .DEPTH(16), .ADDR_W(4), .DATA_W(16), .VERIFY_EN(0)
    ) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .mode(mode_b),
        .verify(verify_b), .fill_value(fv_b), .rom_en(rom_en_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .ram_we(ram_we_b),
        .ram_re(ram_re_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b), .busy(busy_b), .done(done_b), .err(err_b),
        .err_addr(err_addr_b)
    );

    always @(posedge clk) begin
        if (rom_en_b) rom_data_b <= 16'h1200 + 16'(rom_addr_b);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_a(input string t, input logic m, input logic v,
                         input logic [7:0] f, input int extra,
                         input bit chain, input bit b2b,
                         input int exp_done, input int exp_nr,
                         input int exp_last_re, input logic exp_err,
                         input logic [4:0] exp_eaddr);
        int nw = 0, nr = 0, bad = 0, ovl = 0, ndone = 0;
        int first_we = -1, done_c = -1, last_re = -1;
        logic [7:0] expd;
        @(negedge clk);
        if (b2b) check({t, "_idle"}, 32'(busy), 32'd0);
        start = 1; mode = m; verify = v; fv = f;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = (c == extra);
            if (c == extra) begin
                mode = ~m; verify = ~v; fv = ~f;
            end
            if (ram_we) begin
                if (first_we < 0) first_we = c;
                expd = m ? f : 8'(nw + 16);
                if (ram_addr !== 5'(nw) || ram_wdata !== expd) bad++;
                nw++;
            end
            if (ram_re) begin
                nr++;
                last_re = int'(ram_addr);
            end
            if (ram_we && ram_re) ovl++;
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && (chain || c >= done_c + 3)) break;
        end
        start = chain;
        check({t, "_first_we"}, 32'(first_we), 32'd2);
        check({t, "_nwrites"}, 32'(nw), 32'd32);
        check({t, "_wr_bad"}, 32'(bad), 32'd0);
        check({t, "_done_cyc"}, 32'(done_c), 32'(exp_done));
        check({t, "_ndone"}, 32'(ndone), 32'd1);
        check({t, "_nreads"}, 32'(nr), 32'(exp_nr));
        check({t, "_last_re"}, 32'(last_re), 32'(exp_last_re));
        check({t, "_overlap"}, 32'(ovl), 32'd0);
        check({t, "_err"}, 32'(err), 32'(exp_err));
        check({t, "_err_addr"}, 32'(err_addr), 32'(exp_eaddr));
    endtask

    initial begin
        int found, nd, nwb, badb, firstb, doneb, ndb, nrb;
        repeat (3) @(negedge clk);
        check("rst_a", {3'b0, rom_en, rom_addr, ram_we, ram_re, ram_addr,
              ram_wdata, busy, done, err, err_addr}, 32'd0);
        check("rst_b", {10'b0, rom_en_b, ram_we_b, ram_re_b, ram_addr_b,
              ram_wdata_b, busy_b, done_b, err_b}, 32'd0);
        rst_n = 1;

        run_a("copy", 0, 0, 8'h00, -1, 0, 0, 34, 0, -1, 0, 5'd0);
        run_a("fillv", 1, 1, 8'hA5, -1, 0, 0, 67, 32, 31, 0, 5'd0);
        corrupt = 1;
        run_a("mism", 0, 1, 8'h00, -1, 0, 0, 43, 9, 8, 1, 5'd7);
        corrupt = 0;
        run_a("busy", 0, 0, 8'h3C, 5, 1, 0, 34, 0, -1, 0, 5'd0);
        run_a("b2b", 1, 0, 8'h5A, -1, 0, 1, 34, 0, -1, 0, 5'd0);

        @(negedge clk);
        start = 1; mode = 0; verify = 0;
        found = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 0;
            if (ram_we && ram_addr == 5'd12) begin
                found = 1;
                break;
            end
        end
        check("rst_found", 32'(found), 32'd1);
        rst_n = 0;
        #1;
        check("rst_outs", {3'b0, rom_en, rom_addr, ram_we, ram_re, ram_addr,
              ram_wdata, busy, done, err, err_addr}, 32'd0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("rst_nodone", 32'(nd), 32'd0);
        rst_n = 1;
        run_a("post_rst", 0, 0, 8'h00, -1, 0, 0, 34, 0, -1, 0, 5'd0);

        @(negedge clk);
        start_b = 1; mode_b = 0; verify_b = 1;
        nwb = 0; badb = 0; firstb = -1; doneb = -1; ndb = 0; nrb = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start_b = 0;
            if (ram_we_b) begin
                if (firstb < 0) firstb = c;
                if (ram_addr_b !== 4'(nwb) ||
                    ram_wdata_b !== 16'h1200 + 16'(nwb)) badb++;
                nwb++;
            end
            if (ram_re_b) nrb++;
            if (done_b) begin
                ndb++;
                if (doneb < 0) doneb = c;
            end
            if (doneb >= 0 && c >= doneb + 3) break;
        end
        check("b_first_we", 32'(firstb), 32'd2);
        check("b_nwrites", 32'(nwb), 32'd16);
        check("b_wr_bad", 32'(badb), 32'd0);
        check("b_done_cyc", 32'(doneb), 32'd18);
        check("b_ndone", 32'(ndb), 32'd1);
        check("b_nreads", 32'(nrb), 32'd0);
        check("b_err", 32'(err_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
